// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : MIPS IF stage - PC register, word-addressed instruction memory
//            and RUN/STEP/HALT fetch control. Optional macro
//            IF_BRANCH_FLUSH_EN squashes the wrong-path word on redirect.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter int          MEM_DEPTH = 256,
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_step_mode,
  input  logic              i_step,
  input  logic              i_stall,
  input  logic              i_pc_src,
  input  logic [31:0]       i_pc_target,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [31:0]       i_wr_data,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_pc_plus4,
  output logic [31:0]       o_instruction,
  output logic              o_fetch_valid,
  output logic              o_halted,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t            state_q;
  logic [31:0]       pc_q, pc_d;
  logic              halted_q;
  logic [31:0]       mem_q [MEM_DEPTH];

  logic [ADDR_W-1:0] rd_idx;
  logic [31:0]       fetched;
  logic              go, active, redirect, halt_hit, fetch_valid;
  logic              unused_target_bits;

  assign rd_idx             = pc_q[ADDR_W+1:2];
  assign fetched            = mem_q[rd_idx];
  assign unused_target_bits = ^i_pc_target[1:0];

  always_comb begin
    go          = (state_q == S_RUN) || ((state_q == S_STEP) && i_step);
    active      = go && !i_stall;
    redirect    = active && i_pc_src;
    // A redirect outranks a HALT word sitting on the wrong path.
    halt_hit    = active && !i_pc_src && (fetched == HALT_WORD);
    fetch_valid = active && !halt_hit;
    pc_d        = pc_q;
    if (redirect)
      pc_d = {i_pc_target[31:2], 2'b00};
    else if (fetch_valid)
      pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      pc_q     <= 32'd0;
      halted_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        S_IDLE: begin
          if (i_start)
            state_q <= i_step_mode ? S_STEP : S_RUN;
        end
        S_RUN, S_STEP: begin
          if (halt_hit) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
          end
        end
        default: state_q <= S_HALTED;
      endcase
    end
  end

  // Program load is only accepted while the core is idle.
  always_ff @(posedge clk) begin
    if (i_wr_en && (state_q == S_IDLE) && !i_reset)
      mem_q[i_wr_addr] <= i_wr_data;
  end

  always_comb begin
    case (state_q)
      S_IDLE:   o_instruction = 32'd0;
      S_HALTED: o_instruction = HALT_WORD;
      default:  o_instruction = fetched;
    endcase
`ifdef IF_BRANCH_FLUSH_EN
    if (redirect)
      o_instruction = 32'd0;
`else
`endif
  end

  assign o_pc          = pc_q;
  assign o_pc_plus4    = pc_q + 32'd4;
  assign o_fetch_valid = fetch_valid;
  assign o_halted      = halted_q;
  assign o_state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Purpose  : Directed and randomized bench for instruction_fetch against a
//            behavioural fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0, i_start = 1'b0, i_step_mode = 1'b0, i_step = 1'b0;
  logic        i_stall = 1'b0, i_pc_src = 1'b0, i_wr_en = 1'b0;
  logic [31:0] i_pc_target = 32'd0, i_wr_data = 32'd0;
  logic [7:0]  i_wr_addr = 8'd0;
  logic [31:0] o_pc, o_pc_plus4, o_instruction;
  logic        o_fetch_valid, o_halted;
  logic [1:0]  o_state;

  int checks = 0;
  int errors = 0;

  // Behavioural model: architectural PC, mode number and a memory image.
  logic [31:0] m_pc = 32'd0;
  int          m_state = 0;
  logic [31:0] m_mem [256];

  instruction_fetch dut (
    .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_step_mode(i_step_mode),
    .i_step(i_step), .i_stall(i_stall), .i_pc_src(i_pc_src),
    .i_pc_target(i_pc_target), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4),
    .o_instruction(o_instruction), .o_fetch_valid(o_fetch_valid),
    .o_halted(o_halted), .o_state(o_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit advancing();
    return ((m_state == 1) || (m_state == 2 && i_step)) && !i_stall;
  endfunction

  task automatic check_model();
    logic [31:0] word, e_instr;
    bit          e_fv;
    word    = m_mem[m_pc[9:2]];
    e_fv    = advancing() && (i_pc_src || word != HALT);
    e_instr = (m_state == 0) ? 32'd0 : (m_state == 3) ? HALT : word;
`ifdef IF_BRANCH_FLUSH_EN
    if (advancing() && i_pc_src) e_instr = 32'd0;
`endif
    chk("pc", o_pc, m_pc);
    chk("pc_plus4", o_pc_plus4, m_pc + 32'd4);
    chk("instruction", o_instruction, e_instr);
    chk("fetch_valid", {31'd0, o_fetch_valid}, {31'd0, e_fv});
    chk("halted", {31'd0, o_halted}, {31'd0, m_state == 3});
    chk("state", {30'd0, o_state}, m_state);
  endtask

  task automatic model_step();
    logic [31:0] word;
    word = m_mem[m_pc[9:2]];
    if (i_reset) begin
      m_pc    = 32'd0;
      m_state = 0;
    end else if (m_state == 0) begin
      if (i_wr_en) m_mem[i_wr_addr] = i_wr_data;
      if (i_start) m_state = i_step_mode ? 2 : 1;
    end else if (m_state != 3 && advancing()) begin
      if (i_pc_src)          m_pc = i_pc_target & ~32'd3;
      else if (word == HALT) m_state = 3;
      else                   m_pc = m_pc + 32'd4;
    end
  endtask

  // Inputs are driven at the falling edge; outputs checked 1 unit later.
  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_reset = 1'b1; tick(); i_reset = 1'b0;
  endtask

  task automatic start(input logic mode);
    i_start = 1'b1; i_step_mode = mode; tick(); i_start = 1'b0;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] d);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d; tick(); i_wr_en = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    @(negedge clk);
    do_reset();
    chk("reset_pc", o_pc, 32'd0);
    chk("reset_state", {30'd0, o_state}, 32'd0);
    chk("reset_instr", o_instruction, 32'd0);

    // Fill memory with non-HALT words so every read is defined.
    for (int a = 0; a < 256; a++) begin
      r = $urandom();
      if (r == HALT) r = 32'd0;
      write_word(a[7:0], r);
    end

    // Single-step: PC only moves on a step pulse.
    do_reset();
    start(1'b1);
    for (int k = 0; k < 5; k++) tick();
    chk("step_idle_pc", o_pc, 32'd0);
    chk("step_state", {30'd0, o_state}, 32'd2);
    for (int k = 1; k <= 3; k++) begin
      i_step = 1'b1; tick(); i_step = 1'b0; tick();
      chk("step_pc", o_pc, 32'(4 * k));
    end

    do_reset();
    write_word(8'd0, 32'h20010005);
    write_word(8'd1, 32'h20020003);
    write_word(8'd2, HALT);

    // Continuous run into HALT.
    do_reset();
    start(1'b0);
    chk("run_instr0", o_instruction, 32'h20010005);
    tick();
    chk("run_pc4", o_pc, 32'd4);
    tick();
    chk("run_pc8", o_pc, 32'd8);
    chk("run_halt_word", o_instruction, HALT);
    tick();
    chk("halt_state", {30'd0, o_state}, 32'd3);
    chk("halt_flag", {31'd0, o_halted}, 32'd1);
    chk("halt_fv", {31'd0, o_fetch_valid}, 32'd0);
    i_start = 1'b1; i_step = 1'b1; tick(); i_start = 1'b0; i_step = 1'b0;
    chk("halt_pc_frozen", o_pc, 32'd8);

    // Stall holds PC.
    do_reset();
    start(1'b0);
    tick();
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_pc", o_pc, 32'd4);
      chk("stall_fv", {31'd0, o_fetch_valid}, 32'd0);
      tick();
    end
    i_stall = 1'b0;
    tick();
    chk("stall_resume_pc", o_pc, 32'd8);

    // Redirect over the HALT word, first blocked by a stall.
    do_reset();
    start(1'b0);
    tick(); tick();
    i_stall = 1'b1; i_pc_src = 1'b1; i_pc_target = 32'h40;
    tick();
    chk("stall_redirect_pc", o_pc, 32'd8);
    i_stall = 1'b0;
    #1;
`ifdef IF_BRANCH_FLUSH_EN
    chk("redirect_instr", o_instruction, 32'd0);
`else
    chk("redirect_instr", o_instruction, HALT);
`endif
    tick();
    i_pc_src = 1'b0;
    chk("redirect_pc", o_pc, 32'h40);

    // Program-load writes outside IDLE are dropped.
    do_reset();
    start(1'b0);
    i_wr_en = 1'b1; i_wr_addr = 8'd0; i_wr_data = 32'h12345678; tick(); i_wr_en = 1'b0;
    do_reset();
    start(1'b0);
    chk("run_write_ignored", o_instruction, 32'h20010005);
    do_reset();
    write_word(8'd0, 32'h12345678);
    start(1'b0);
    chk("idle_write_lands", o_instruction, 32'h12345678);
    do_reset();
    write_word(8'd0, 32'h20010005);

    // Reset mid-run at pc 0x10 (redirect target low bits ignored).
    start(1'b0);
    i_pc_src = 1'b1; i_pc_target = 32'h13; tick(); i_pc_src = 1'b0;
    chk("redirect_align_pc", o_pc, 32'h10);
    do_reset();
    chk("midrun_reset_pc", o_pc, 32'd0);
    chk("midrun_reset_state", {30'd0, o_state}, 32'd0);
    chk("midrun_reset_instr", o_instruction, 32'd0);
    start(1'b0);
    chk("mem_kept", o_instruction, 32'h20010005);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      i_reset     = ($urandom_range(63) == 0);
      i_start     = ($urandom_range(7) == 0);
      i_step_mode = $urandom_range(1);
      i_step      = $urandom_range(1);
      i_stall     = ($urandom_range(4) == 0);
      i_pc_src    = ($urandom_range(7) == 0);
      i_pc_target = $urandom_range(1) ? ($urandom() & 32'h3ff) : $urandom();
      i_wr_en     = ($urandom_range(3) == 0);
      i_wr_addr   = 8'($urandom());
      i_wr_data   = ($urandom_range(5) == 0) ? HALT : $urandom();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage of the 5-stage MIPS pipeline: PC register, word-addressed instruction memory and a fetch-control FSM.
- Directly feeds the IF/ID pipeline register with the fetched instruction and PC+4.
- Memory is loaded by the debug unit before execution.
- Runs in continuous or single-step mode; freezes on the HALT instruction.

Parameters:
- MEM_DEPTH, 256, instruction memory depth in 32-bit words (power of 2).
- ADDR_W, 8, word-address width; equals log2(MEM_DEPTH).
- HALT_WORD, 32'hFFFFFFFF, encoding of the HALT instruction.

Ports:
- clk  in  1  system clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  pulse; leaves IDLE and starts fetching.
- i_step_mode  in  1  sampled with i_start: 1 = STEP, 0 = RUN.
- i_step  in  1  single-step pulse; used in STEP only.
- i_stall  in  1  hazard-unit stall; holds PC.
- i_pc_src  in  1  redirect request (taken branch or jump) from ID.
- i_pc_target  in  32  redirect target byte address.
- i_wr_en  in  1  program-load write enable.
- i_wr_addr  in  ADDR_W  program-load word address.
- i_wr_data  in  32  program-load data.
- o_pc  out  32  current PC (byte address).
- o_pc_plus4  out  32  o_pc + 4.
- o_instruction  out  32  instruction at o_pc, gated per Behaviour.
- o_fetch_valid  out  1  high in cycles where PC updates.
- o_halted  out  1  high in HALTED.
- o_state  out  2  FSM state: IDLE=0, RUN=1, STEP=2, HALTED=3.

Behaviour:
- Reset (i_reset=1 at posedge): pc=0, state=IDLE, o_halted=0. Memory contents are not cleared.
- Reset has priority over all other inputs in every state, including mid-run.
- Memory:
  - Synchronous write, asynchronous read.
  - Read index = pc[ADDR_W+1:2]; upper PC bits are ignored, so addresses wrap modulo MEM_DEPTH words.
  - Writes take effect only in IDLE; i_wr_en in any other state is ignored.
- o_instruction:
  - 0 (NOP) in IDLE.
  - mem[index] in RUN, STEP and HALTED.
  - Zero-latency, combinational from pc.
- o_pc_plus4: pc + 4, modulo 2^32.
- FSM:
  - IDLE: i_start → RUN if i_step_mode=0, else STEP. PC is held.
  - RUN: go = 1 every cycle.
  - STEP: go = i_step.
  - RUN/STEP: if go && !i_stall && mem[index]==HALT_WORD && !i_pc_src → HALTED, PC held.
  - HALTED: PC frozen, o_halted=1, o_instruction = HALT_WORD. i_start and i_step are ignored. Exit only by reset.
- PC update in RUN/STEP, priority high→low:
  - i_stall=1: hold; o_fetch_valid=0.
  - go=0: hold; o_fetch_valid=0.
  - i_pc_src=1: pc ← i_pc_target; o_fetch_valid=1. Redirect overrides a HALT word on the wrong path.
  - Fetched word == HALT_WORD: hold, enter HALTED; o_fetch_valid=0.
  - Otherwise: pc ← pc+4; o_fetch_valid=1.
- Stall together with redirect: stall wins. ID holds the branch, so the redirect is re-presented next cycle.
- i_pc_target[1:0] is ignored: pc ← {i_pc_target[31:2], 2'b00}.
- i_step held high in STEP advances once per cycle; the debug unit supplies single-cycle pulses.

Optional Feature:
- Macro: IF_BRANCH_FLUSH_EN.
- Defined: when the redirect is applied (i_pc_src=1 && !i_stall && go), o_instruction is forced to 0 in that cycle. The wrong-path instruction is squashed before IF/ID captures it.
- Undefined: o_instruction is unmodified, so the sequential instruction enters IF/ID (branch-delay-slot semantics).

Test Plan:
- Load 0x20010005, 0x20020003, HALT_WORD at addresses 0..2; i_start with i_step_mode=0 → o_pc 0,4,8 on successive cycles, then held at 8; o_halted=1, o_state=3, o_fetch_valid=0 from the halt cycle on.
- RUN with i_stall high for 3 cycles at pc=4 → o_pc stays 4, o_fetch_valid=0; resumes at 8 the cycle after stall drops.
- RUN at pc=8, i_pc_src=1, i_pc_target=0x40 → next o_pc=0x40. With the macro defined, o_instruction=0 in the redirect cycle; undefined, o_instruction=mem[2]. Stall+redirect in the same cycle → o_pc stays 8.
- STEP mode: no i_step for 5 cycles → o_pc=0; three i_step pulses → o_pc=4, 8, 12, one per pulse.
- i_wr_en to address 0 with data 0x12345678 during RUN → mem[0] unchanged (re-read after reset shows the original word); in IDLE the same write lands.
- Reset asserted mid-RUN at pc=0x10 → next cycle o_pc=0, o_state=0, o_instruction=0; memory still holds the program.
